// File: rtl/synch_interval_timer_if.sv
// synch_interval_timer_if
// Control/status bundle for the interval timer.
//   start  : start request (sampled only while the timer is idle)
//   stop   : abort request, wins over start and over terminal count
//   mode   : 0 = one-shot, 1 = periodic; captured on an accepted start
//   period : interval length in cycles; captured on an accepted start
//   busy   : high while an interval is running
//   done   : one-cycle pulse when an interval completes
//   count  : elapsed cycles within the current interval
// master drives the requests, slave (the timer) drives the status.
interface synch_interval_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  modport master (
    output start, stop, mode, period,
    input  busy, done, count
  );

  modport slave (
    input  start, stop, mode, period,
    output busy, done, count
  );
endinterface

// File: rtl/synch_interval_timer.sv
// synch_interval_timer
// Programmable interval timer: counts clock cycles up to a captured period
// and emits a registered one-cycle done pulse, either once (one-shot) or
// every period cycles (periodic, auto-reload with no gap cycle).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears all state and outputs
//   bus   : slave side of synch_interval_timer_if (requests in, status out)
module synch_interval_timer #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  synch_interval_timer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] per_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] last_d;
  logic             term_d;
  logic [WIDTH-1:0] count_inc_d;

  // Terminal detect: per_q-1 wraps in WIDTH bits, but per_q=0 never reaches RUN.
  always_comb begin
    last_d      = per_q - {{(WIDTH-1){1'b0}}, 1'b1};
    count_inc_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    if (count_q == last_d) begin
      term_d = 1'b1;
    end else begin
      term_d = 1'b0;
    end
  end

  // Timer FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= {WIDTH{1'b0}};
      per_q   <= {WIDTH{1'b0}};
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else if (bus.start) begin
            per_q  <= bus.period;
            mode_q <= bus.mode;
            if (bus.period == {WIDTH{1'b0}}) begin
              // Zero-length interval completes immediately without running.
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              count_q <= {WIDTH{1'b0}};
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (bus.stop) begin
            // Abort wins even on the terminal cycle: no done for this interval.
            state_q <= IDLE;
            count_q <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
          end else if (term_d) begin
            done_q  <= 1'b1;
            count_q <= {WIDTH{1'b0}};
            if (!mode_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              // Periodic: next interval starts on this same edge.
              state_q <= RUN;
            end
          end else begin
            count_q <= count_inc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= {WIDTH{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_synch_interval_timer.sv
// tb_synch_interval_timer
// Self-checking bench: each stimulus cycle pushes the expected status for the
// following edge into a scoreboard queue, which is popped and compared once
// the DUT has updated.
module tb_synch_interval_timer;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;
  } exp_t;

  logic clk;
  logic reset;
  int   checks_cnt;
  int   errors_cnt;
  exp_t exp_q[$];

  synch_interval_timer_if #(.WIDTH(WIDTH)) tif ();

  synch_interval_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt = checks_cnt + 1;
    if (obs !== exp) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic cycle(input string tag, input logic st, input logic sp, input logic md,
                       input logic [WIDTH-1:0] per, input logic eb, input logic ed,
                       input logic [WIDTH-1:0] ec);
    exp_t e;
    @(negedge clk);
    tif.start  = st;
    tif.stop   = sp;
    tif.mode   = md;
    tif.period = per;
    exp_q.push_back({eb, ed, ec});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_busy"},  {31'd0, tif.busy},  {31'd0, e.busy});
      check_eq({tag, "_done"},  {31'd0, tif.done},  {31'd0, e.done});
      check_eq({tag, "_count"}, {28'd0, tif.count}, {28'd0, e.count});
    end
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"},  {31'd0, tif.busy},  32'd0);
    check_eq({tag, "_done"},  {31'd0, tif.done},  32'd0);
    check_eq({tag, "_count"}, {28'd0, tif.count}, 32'd0);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    tif.start  = 1'b0;
    tif.stop   = 1'b0;
    tif.mode   = 1'b0;
    tif.period = 4'd0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    idle("post_reset");

    // One-shot, period 5.
    cycle("os5_start", 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k < 5; k++) cycle("os5_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, k[3:0]);
    cycle("os5_done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
    idle("os5_after");

    // Periodic, period 3, ten cycles then stop.
    cycle("per3_start", 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 10; k++)
      cycle("per3_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, ((k % 3) == 0), 4'(k % 3));
    cycle("per3_stop", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    idle("per3_after");

    // Stop on the terminal cycle of a one-shot period 4.
    cycle("stopterm_start", 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k < 4; k++) cycle("stopterm_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, k[3:0]);
    cycle("stopterm_stop", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    idle("stopterm_after");

    // Period 0: immediate done, never busy.
    cycle("p0_start", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
    idle("p0_after");

    // Period 15: maximum, count peaks at 14.
    cycle("p15_start", 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k < 15; k++) cycle("p15_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, k[3:0]);
    cycle("p15_done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
    idle("p15_after");

    // Period 1 periodic: done every cycle until stop.
    cycle("p1_start", 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 4; k++) cycle("p1_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0);
    cycle("p1_stop", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

    // Start during RUN is ignored: period 6 one-shot still completes at 6.
    cycle("ign_start", 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 4'd0);
    cycle("ign_restart", 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd1);
    for (int k = 2; k < 6; k++) cycle("ign_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, k[3:0]);
    cycle("ign_done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
    idle("ign_after");

    // start and stop together in IDLE: stays idle.
    cycle("startstop", 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'd0);
    idle("startstop_after");

    // Async reset mid-interval at count 3 of 8.
    cycle("ar_start", 1'b1, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 3; k++) cycle("ar_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, k[3:0]);
    #2;
    reset = 1'b1;
    #1;
    check_zero("ar_async");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) idle("ar_after");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
